morse_tx: RTL and testbench

- Parametrised Morse transmitter; successor to the fixed-pattern digit sender.
- Accepts one ASCII character per valid/ready handshake and looks up its dot/dash pattern (A-Z, a-z, 0-9, space).
- Keys the LED matrix enable and the buzzer with standard ITU timing: dash = 3 units, element gap = 1, character gap = 3, word gap = 7.
- Sits between the keypad/UART character source and the matrix/segment display drivers.

---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_lut.sv | 70 +++++++
 rtl/morse_tx.sv | 168 ++++++++++++++++
 tb/tb_morse_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, segment glyphs and ASCII helpers for morse_tx.
`default_nettype none

package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_MARK     = 3'd2,
    S_ELEM_GAP = 3'd3,
    S_CHAR_GAP = 3'd4,
    S_WORD_GAP = 3'd5
  } state_t;

  localparam logic [7:0] SEG_DOT     = 8'h80;
  localparam logic [7:0] SEG_DASH    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] CASE_FOLD   = 8'h20;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - CASE_FOLD;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/morse_lut.sv
// morse_lut: ITU code lookup for A-Z and 0-9; pattern is LSB-first, 1 = dash, len 0 = unsupported.
`default_nettype none

module morse_lut #(
  parameter int MAX_ELEM = 5
) (
  input  logic [7:0]                     char,
  output logic [$clog2(MAX_ELEM+1)-1:0]  len,
  output logic [MAX_ELEM-1:0]            pat
);

  localparam int LW = $clog2(MAX_ELEM + 1);
  localparam int PW = (MAX_ELEM > 5) ? MAX_ELEM : 5;

  logic [7:0]    raw;
  logic [PW-1:0] wide_pat;
  logic          fits;

  always_comb begin
    raw = 8'h00;
    case (char)
      "A": raw = {3'd2, 5'b00010};
      "B": raw = {3'd4, 5'b00001};
      "C": raw = {3'd4, 5'b00101};
      "D": raw = {3'd3, 5'b00001};
      "E": raw = {3'd1, 5'b00000};
      "F": raw = {3'd4, 5'b00100};
      "G": raw = {3'd3, 5'b00011};
      "H": raw = {3'd4, 5'b00000};
      "I": raw = {3'd2, 5'b00000};
      "J": raw = {3'd4, 5'b01110};
      "K": raw = {3'd3, 5'b00101};
      "L": raw = {3'd4, 5'b00010};
      "M": raw = {3'd2, 5'b00011};
      "N": raw = {3'd2, 5'b00001};
      "O": raw = {3'd3, 5'b00111};
      "P": raw = {3'd4, 5'b00110};
      "Q": raw = {3'd4, 5'b01011};
      "R": raw = {3'd3, 5'b00010};
      "S": raw = {3'd3, 5'b00000};
      "T": raw = {3'd1, 5'b00001};
      "U": raw = {3'd3, 5'b00100};
      "V": raw = {3'd4, 5'b01000};
      "W": raw = {3'd3, 5'b00110};
      "X": raw = {3'd4, 5'b01001};
      "Y": raw = {3'd4, 5'b01101};
      "Z": raw = {3'd4, 5'b00011};
      "0": raw = {3'd5, 5'b11111};
      "1": raw = {3'd5, 5'b11110};
      "2": raw = {3'd5, 5'b11100};
      "3": raw = {3'd5, 5'b11000};
      "4": raw = {3'd5, 5'b10000};
      "5": raw = {3'd5, 5'b00000};
      "6": raw = {3'd5, 5'b00001};
      "7": raw = {3'd5, 5'b00011};
      "8": raw = {3'd5, 5'b00111};
      "9": raw = {3'd5, 5'b01111};
      default: raw = 8'h00;
    endcase
  end

  // Codes longer than the configured pattern width are reported as unsupported.
  assign fits     = int'(raw[7:5]) <= MAX_ELEM;
  assign wide_pat = PW'(raw[4:0]);
  assign len      = fits ? LW'(raw[7:5]) : '0;
  assign pat      = fits ? wide_pat[MAX_ELEM-1:0] : '0;

endmodule

`default_nettype wire

// File: rtl/morse_tx.sv
// morse_tx: handshake-fed ITU Morse keyer driving key/beep, a segment history and done/bad_char pulses.
`default_nettype none

module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYC       = 50000,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int MAX_ELEM       = 5,
  parameter int DISP_SLOTS     = 8,
  parameter int TONE_DIV       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              char_in,
  input  logic                    char_valid,
  output logic                    char_ready,
  output logic                    key,
  output logic                    beep,
  output logic [8*DISP_SLOTS-1:0] disp_val,
  output logic                    busy,
  output logic                    done,
  output logic                    bad_char
);

  localparam int LW   = $clog2(MAX_ELEM + 1);
  localparam int IW   = (MAX_ELEM > 1) ? $clog2(MAX_ELEM) : 1;
  localparam int CW   = $clog2(UNIT_CYC);
  localparam int TW   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int MU1  = (DASH_UNITS > CHAR_GAP_UNITS) ? DASH_UNITS : CHAR_GAP_UNITS;
  localparam int MAXU = (MU1 > WORD_GAP_UNITS) ? MU1 : WORD_GAP_UNITS;
  localparam int UW   = $clog2(MAXU + 1);

  state_t          state;
  logic [7:0]      char_q;
  logic [7:0]      folded;
  logic [LW-1:0]   len;
  logic [MAX_ELEM-1:0] pat;
  logic [CW-1:0]   cyc;
  logic [UW-1:0]   units;
  logic [UW-1:0]   target;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   nxt_idx;
  logic [TW-1:0]   tone;
  logic            cyc_last, cyc_prelast, unit_last, state_last, last_elem;

  assign folded = fold_case(char_q);

  morse_lut #(.MAX_ELEM(MAX_ELEM)) u_lut (
    .char (folded),
    .len  (len),
    .pat  (pat)
  );

  always_comb begin
    target = UW'(1);
    case (state)
      S_MARK:     target = pat[idx] ? UW'(DASH_UNITS) : UW'(1);
      S_CHAR_GAP: target = UW'(CHAR_GAP_UNITS);
      S_WORD_GAP: target = UW'(WORD_GAP_UNITS);
      default:    target = UW'(1);
    endcase
  end

  assign nxt_idx     = idx + IW'(1);
  assign cyc_last    = (cyc == CW'(UNIT_CYC - 1));
  assign cyc_prelast = (cyc == CW'(UNIT_CYC - 2));
  assign unit_last   = (units == target - UW'(1));
  assign state_last  = cyc_last && unit_last;
  assign last_elem   = (int'(idx) == int'(len) - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      char_q     <= 8'h00;
      cyc        <= '0;
      units      <= '0;
      idx        <= '0;
      tone       <= '0;
      key        <= 1'b0;
      beep       <= 1'b0;
      disp_val   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bad_char   <= 1'b0;
      char_ready <= 1'b1;
    end else begin
      done     <= 1'b0;
      bad_char <= 1'b0;
      beep     <= 1'b0;
      tone     <= '0;
      if (cyc_last) begin
        cyc   <= '0;
        units <= units + UW'(1);
      end else begin
        cyc <= cyc + CW'(1);
      end

      case (state)
        S_IDLE: begin
          cyc   <= '0;
          units <= '0;
          if (char_valid) begin
            char_q     <= char_in;
            state      <= S_LOAD;
            char_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          cyc   <= '0;
          units <= '0;
          idx   <= '0;
          if (char_q == ASCII_SPACE) begin
            state <= S_WORD_GAP;
          end else if (len == '0) begin
            bad_char   <= 1'b1;
            state      <= S_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state    <= S_MARK;
            key      <= 1'b1;
            disp_val <= {disp_val[8*DISP_SLOTS-9:0], pat[0] ? SEG_DASH : SEG_DOT};
          end
        end
        S_MARK: begin
          if (state_last) begin
            key   <= 1'b0;
            cyc   <= '0;
            units <= '0;
            state <= last_elem ? S_CHAR_GAP : S_ELEM_GAP;
          end else if (tone == TW'(TONE_DIV - 1)) begin
            beep <= ~beep;
          end else begin
            beep <= beep;
            tone <= tone + TW'(1);
          end
        end
        S_ELEM_GAP: begin
          if (state_last) begin
            idx      <= nxt_idx;
            key      <= 1'b1;
            cyc      <= '0;
            units    <= '0;
            state    <= S_MARK;
            disp_val <= {disp_val[8*DISP_SLOTS-9:0], pat[nxt_idx] ? SEG_DASH : SEG_DOT};
          end
        end
        S_CHAR_GAP, S_WORD_GAP: begin
          // Registered pulse: raised one cycle early so it lands on the final gap cycle.
          if (cyc_prelast && unit_last) done <= 1'b1;
          if (state_last) begin
            state      <= S_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_morse_tx.sv
// tb_morse_tx: table-driven and randomized checks of morse_tx against a string-based Morse timing model.
`default_nettype none

module tb_morse_tx;

  localparam int UNIT  = 4;
  localparam int TDIV  = 1;
  localparam int SLOTS = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [7:0]            char_in = 8'h00;
  logic                  char_valid = 1'b0;
  logic                  char_ready, key, beep, busy, done, bad_char;
  logic [8*SLOTS-1:0]    disp_val;

  always #5 clk = ~clk;

  morse_tx #(.UNIT_CYC(UNIT), .TONE_DIV(TDIV), .DISP_SLOTS(SLOTS)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key        (key),
    .beep       (beep),
    .disp_val   (disp_val),
    .busy       (busy),
    .done       (done),
    .bad_char   (bad_char)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] mdl_disp = '0;

  typedef struct {
    logic [7:0]  ch;
    bit          hold;
    logic [7:0]  nxt;
    int          exp_done;
    logic [15:0] exp_lo;
    bit          exp_bad;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string code_of(input logic [7:0] c_in);
    logic [7:0] c;
    c = c_in;
    if (c >= "a" && c <= "z") c = c - 8'd32;
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    while (!char_ready && w < 300) begin
      tick();
      w++;
    end
    check("ready_wait", char_ready, 1);
  endtask

  // Sends one character and checks every cycle against a waveform built from the code string.
  task automatic run_char(input logic [7:0] ch, input bit hold, input logic [7:0] nxt,
                          output int done_at, output bit saw_bad);
    string code;
    bit    is_space, is_bad;
    bit    qk[$];
    int    qp[$];
    int    nt;
    code     = code_of(ch);
    is_space = (ch == 8'h20);
    is_bad   = !is_space && code.len() == 0;
    done_at  = 0;
    saw_bad  = 0;
    qk.push_back(1'b0); qp.push_back(-1);
    if (is_space) begin
      for (int k = 0; k < 7 * UNIT; k++) begin qk.push_back(1'b0); qp.push_back(-1); end
    end else if (!is_bad) begin
      for (int i = 0; i < code.len(); i++) begin
        int m, g;
        m = (code[i] == "-") ? 3 * UNIT : UNIT;
        g = (i == code.len() - 1) ? 3 * UNIT : UNIT;
        for (int k = 0; k < m; k++) begin qk.push_back(1'b1); qp.push_back(k); end
        for (int k = 0; k < g; k++) begin qk.push_back(1'b0); qp.push_back(-1); end
        mdl_disp = {mdl_disp[55:0], (code[i] == "-") ? 8'h08 : 8'h80};
      end
    end

    wait_ready();
    char_in    = ch;
    char_valid = 1'b1;
    tick();
    if (hold) char_in = nxt;
    else begin
      char_valid = 1'b0;
      char_in    = 8'($urandom);
    end

    if (is_bad) begin
      check("bad_load_busy", busy, 1);
      check("bad_load_ready", char_ready, 0);
      check("bad_load_key", key, 0);
      tick();
      saw_bad = bad_char;
      check("bad_pulse", bad_char, 1);
      check("bad_ready", char_ready, 1);
      check("bad_busy", busy, 0);
      check("bad_done", done, 0);
      check("bad_key", key, 0);
      tick();
      check("bad_pulse_end", bad_char, 0);
    end else begin
      nt = qk.size();
      for (int t = 1; t <= nt; t++) begin
        check("key", key, qk[t-1]);
        check("beep", beep, qk[t-1] ? ((qp[t-1] / TDIV) % 2) : 0);
        check("done", done, (t == nt));
        check("busy", busy, 1);
        check("ready", char_ready, 0);
        if (done && done_at == 0) done_at = t;
        if (bad_char) saw_bad = 1;
        if (t < nt) tick();
      end
      tick();
      check("ready_after_done", char_ready, 1);
      check("done_end", done, 0);
      check("busy_end", busy, 0);
    end
    check("disp", disp_val, mdl_disp);
  endtask

  initial begin
    int  d;
    bit  b;
    string pool;
    pool = "ABCXYZabcxyzKQJ0123456789   #?@[`{";

    tbl[0] = '{8'h45, 1'b0, 8'h00, 17, 16'h0080, 1'b0};
    tbl[1] = '{8'h61, 1'b0, 8'h00, 33, 16'h8008, 1'b0};
    tbl[2] = '{8'h30, 1'b1, 8'h45, 89, 16'h0808, 1'b0};
    tbl[3] = '{8'h45, 1'b0, 8'h00, 17, 16'h0880, 1'b0};
    tbl[4] = '{8'h20, 1'b0, 8'h00, 29, 16'h0880, 1'b0};
    tbl[5] = '{8'h23, 1'b0, 8'h00, 0,  16'h0880, 1'b1};

    #12;
    check("rst_key", key, 0);
    check("rst_beep", beep, 0);
    check("rst_disp", disp_val, 0);
    check("rst_ready", char_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10 rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_char(tbl[i].ch, tbl[i].hold, tbl[i].nxt, d, b);
      check("tbl_done_cycle", d, tbl[i].exp_done);
      check("tbl_disp_lo", disp_val[15:0], tbl[i].exp_lo);
      check("tbl_bad", b, tbl[i].exp_bad);
      if (tbl[i].ch == 8'h30) check("disp40_zero", disp_val[39:0], 40'h0808080808);
    end

    // Reset in the middle of a dash: outputs must drop without waiting for a clock edge.
    wait_ready();
    char_in = "T"; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_key", key, 1);
    check("pre_rst_beep", beep, 1);
    #2 rst = 1'b0;
    #1;
    check("async_key", key, 0);
    check("async_beep", beep, 0);
    check("async_ready", char_ready, 1);
    check("async_busy", busy, 0);
    check("async_disp", disp_val, 0);
    mdl_disp = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    run_char("T", 1'b0, 8'h00, d, b);
    check("t_done_cycle", d, 25);

    for (int r = 0; r < 30; r++) begin
      run_char(pool[$urandom_range(pool.len() - 1)], 1'b0, 8'h00, d, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
